// File: rtl/float_mul_seq.sv
`timescale 1ns/1ps
// Purpose: iterative IEEE-754-style multiplier, generic exponent/fraction widths, RNE rounding, flush-to-zero.
// Latency: MAN_W+3 cycles accept-to-result on the normal path, 1 cycle for special operands (NaN/inf/zero).
// Backpressure: one operation in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake; A, B = {sign, exp, frac}
//   out_valid/out_ready  result handshake; S = product word
//   overflow             finite operands produced a result too large (S = +/-inf)
//   underflow            nonzero result flushed to signed zero
//   invalid              NaN operand or inf*0 (S = canonical quiet NaN)
module float_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   A,
  input  logic [EXP_W+MAN_W:0]   B,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   S,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid
);

  localparam int W     = 1 + EXP_W + MAN_W;
  localparam int M     = MAN_W + 1;          // significand width incl. hidden bit
  localparam int P_W   = 2 * M;              // full product width
  localparam int E_W   = EXP_W + 2;          // signed exponent with headroom for over/underflow
  localparam int CNT_W = $clog2(M + 1);
  localparam int BIAS  = 2 ** (EXP_W - 1) - 1;

  localparam logic signed [E_W-1:0] BIAS_E    = E_W'(BIAS);
  localparam logic signed [E_W-1:0] EXP_MAX   = E_W'(2 ** EXP_W - 1);
  localparam logic signed [E_W-1:0] EXP_ZERO  = '0;
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(M - 1);
  localparam logic [W-1:0]          QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] frac;
  } fp_t;

  typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------
  // Operand classification (combinational, used on the accept edge)
  // ---------------------------------------------------------------
  fp_t  a_f, b_f;
  logic a_exp_max, b_exp_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
  logic res_sign, sp_invalid, sp_inf, special, accept;

  assign a_f = A;
  assign b_f = B;

  assign a_exp_max = &a_f.exp;
  assign b_exp_max = &b_f.exp;
  // exp==0 covers both true zero and denormals, which are flushed to zero
  assign a_zero    = (a_f.exp == '0);
  assign b_zero    = (b_f.exp == '0);
  assign a_nan     = a_exp_max && (a_f.frac != '0);
  assign b_nan     = b_exp_max && (b_f.frac != '0);
  assign a_inf     = a_exp_max && (a_f.frac == '0);
  assign b_inf     = b_exp_max && (b_f.frac == '0);

  assign res_sign   = a_f.sign ^ b_f.sign;
  assign sp_invalid = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
  assign sp_inf     = !sp_invalid && (a_inf || b_inf);
  // any zero or all-ones exponent resolves without running the multiplier
  assign special    = a_zero | b_zero | a_exp_max | b_exp_max;
  assign accept     = in_valid && in_ready;

  // ---------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------
  logic                  sign_q;
  logic signed [E_W-1:0] exp_q;
  logic [P_W-1:0]        mcand;   // multiplicand, shifted left one place per MUL cycle
  logic [M-1:0]          mplier;  // multiplier, shifted right so bit 0 is the current bit
  logic [P_W-1:0]        acc;
  logic [CNT_W-1:0]      cnt;

  // ---------------------------------------------------------------
  // Normalise and round (combinational, consumed on the NORM edge)
  // ---------------------------------------------------------------
  logic                  prod_hi, guard, sticky, round_up;
  logic [M-1:0]          mant;
  logic [M:0]            mant_rnd;
  logic signed [E_W-1:0] exp_n, exp_r;
  logic [MAN_W-1:0]      frac_r;

  always_comb begin
    prod_hi = acc[P_W-1];
    if (prod_hi) begin
      mant   = acc[P_W-1 -: M];
      guard  = acc[M-1];
      sticky = |acc[M-2:0];
    end else begin
      mant   = acc[P_W-2 -: M];
      guard  = acc[M-2];
      sticky = |acc[M-3:0];
    end
    // ties go to the even significand
    round_up = guard && (sticky || mant[0]);
    mant_rnd = {1'b0, mant} + {{M{1'b0}}, round_up};
    exp_n    = exp_q + $signed({{(E_W-1){1'b0}}, prod_hi});
    // a rounding carry-out means the significand became exactly 2.0
    exp_r    = exp_n + $signed({{(E_W-1){1'b0}}, mant_rnd[M]});
    frac_r   = mant_rnd[M] ? mant_rnd[MAN_W:1] : mant_rnd[MAN_W-1:0];
  end

  // ---------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : MUL;
      MUL:  if (cnt == CNT_LAST) state_nxt = NORM;
      NORM: state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // ---------------------------------------------------------------
  // Datapath sequencing
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      S         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sign_q <= res_sign;
            if (special) begin
              overflow  <= 1'b0;
              underflow <= 1'b0;
              invalid   <= sp_invalid;
              if (sp_invalid)
                S <= QNAN;
              else if (sp_inf)
                S <= {res_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
              else
                S <= {res_sign, {(W-1){1'b0}}};
            end else begin
              exp_q  <= $signed({2'b00, a_f.exp}) + $signed({2'b00, b_f.exp}) - BIAS_E;
              mcand  <= {{M{1'b0}}, 1'b1, a_f.frac};
              mplier <= {1'b1, b_f.frac};
              acc    <= '0;
              cnt    <= '0;
            end
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
        end
        NORM: begin
          invalid <= 1'b0;
          if (exp_r >= EXP_MAX) begin
            S         <= {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            overflow  <= 1'b1;
            underflow <= 1'b0;
          end else if (exp_r <= EXP_ZERO) begin
            S         <= {sign_q, {(W-1){1'b0}}};
            overflow  <= 1'b0;
            underflow <= 1'b1;
          end else begin
            S         <= {sign_q, exp_r[EXP_W-1:0], frac_r};
            overflow  <= 1'b0;
            underflow <= 1'b0;
          end
        end
        default: ;  // DONE: result held
      endcase
    end
  end

endmodule
